// File: rtl/epp_pkg.sv
// Shared EPP definitions: host FSM states, bus polarity levels and the command
// record used by both the host and the peripheral side.
package epp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE,
        ST_DONE
    } state_t;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;
    localparam logic WR_WRITE   = 1'b0;
    localparam logic WR_READ    = 1'b1;

    typedef struct packed {
        logic       addr;
        logic       write;
        logic [7:0] wdata;
    } cmd_t;

endpackage

// File: rtl/epp_sync.sv
// Multi-stage single-bit synchroniser for asynchronous EPP handshake lines.
module epp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/epp_host.sv
// EPP bus initiator: turns single local commands into address/data read/write
// cycles, handshaking on the synchronised EppWait with a saturating timeout.
module epp_host
    import epp_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_addr,
    input  logic       cmd_write,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       EppAstb,
    output logic       EppDstb,
    output logic       EppWr,
    input  logic       EppWait,
    inout  wire  [7:0] EppDB
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_MAX = CW'(TIMEOUT_CYC);

    state_t        state;
    state_t        state_next;
    cmd_t          cmd_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          low_seen;
    logic          to_flag;
    logic          wr_q;
    logic [7:0]    rdata_q;
    logic          wait_s;
    logic          drive_db;

    epp_sync #(.STAGES(SYNC_STAGES)) u_wait_sync (
        .clk (clk),
        .rst (rst),
        .d   (EppWait),
        .q   (wait_s)
    );

    assign cnt_inc = (cnt == TIMEOUT_MAX) ? cnt : cnt + 1'b1;

    // State register plus the datapath registers that move with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmd_q    <= '0;
            cnt      <= '0;
            low_seen <= 1'b0;
            to_flag  <= 1'b0;
            wr_q     <= WR_READ;
            rdata_q  <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q.addr  <= cmd_addr;
                        cmd_q.write <= cmd_write;
                        cmd_q.wdata <= cmd_wdata;
                        cnt         <= '0;
                        low_seen    <= 1'b0;
                        to_flag     <= 1'b0;
                        rdata_q     <= 8'h00;
                        wr_q        <= cmd_write ? WR_WRITE : WR_READ;
                    end
                end
                ST_SETUP: begin
                    cnt <= (state_next == ST_STROBE) ? '0 : cnt_inc;
                    if (!wait_s) low_seen <= 1'b1;
                end
                ST_STROBE: begin
                    if (!wait_s) low_seen <= 1'b1;
                    if (state_next == ST_RELEASE) begin
                        cnt <= '0;
                        if (low_seen && wait_s) begin
                            if (!cmd_q.write) rdata_q <= EppDB;
                        end else begin
                            to_flag <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    cnt <= cnt_inc;
                    if (state_next == ST_DONE) begin
                        wr_q <= WR_READ;
                        // Peripheral never dropped Wait: abort and discard any read byte.
                        if (wait_s) begin
                            to_flag <= 1'b1;
                            rdata_q <= 8'h00;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (cmd_valid) state_next = ST_SETUP;
            ST_SETUP:   if (cnt == SETUP_LAST) state_next = ST_STROBE;
            ST_STROBE: begin
                if (low_seen && wait_s)          state_next = ST_RELEASE;
                else if (cnt_inc == TIMEOUT_MAX) state_next = ST_RELEASE;
            end
            ST_RELEASE: if (!wait_s || cnt_inc == TIMEOUT_MAX) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Strobes and bus drive decode straight from state so reset releases them at once.
    always_comb begin
        cmd_ready   = (state == ST_IDLE);
        rsp_valid   = (state == ST_DONE);
        rsp_timeout = (state == ST_DONE) && to_flag;
        EppAstb     = STROBE_OFF;
        EppDstb     = STROBE_OFF;
        if (state == ST_STROBE) begin
            if (cmd_q.addr) EppAstb = STROBE_ON;
            else            EppDstb = STROBE_ON;
        end
        drive_db = cmd_q.write &&
                   (state == ST_SETUP || state == ST_STROBE || state == ST_RELEASE);
    end

    assign EppDB     = drive_db ? cmd_q.wdata : 8'hzz;
    assign EppWr     = wr_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: doc/epp_host.md
Name: epp_host

Overview:
- EPP host (initiator) that drives the Digilent EPP bus toward an EPP peripheral register block.
- A local command/response interface requests address-write, address-read, data-write and data-read cycles; the block sequences the strobes and handshakes on EppWait.
- Used for FPGA-to-FPGA links and as the bus driver in peripheral loopback benches.

Parameters:
- SETUP_CYC, 2, clk cycles EppWr/EppDB are held stable before the strobe falls (min 1).
- TIMEOUT_CYC, 1024, max clk cycles to wait for an EppWait edge before aborting (min 4).
- SYNC_STAGES, 2, flip-flop stages on the EppWait input synchroniser (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and accepting a command.
- cmd_addr  in  1  1 = address cycle (EppAstb), 0 = data cycle (EppDstb).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read byte; holds 0x00 after a write.
- rsp_timeout  out  1  qualifies rsp_valid: the cycle aborted.
- EppAstb  out  1  address strobe, active low.
- EppDstb  out  1  data strobe, active low.
- EppWr  out  1  0 = write, 1 = read.
- EppWait  in  1  peripheral handshake, asynchronous.
- EppDB  inout  8  bidirectional data bus.

Behaviour:
- Reset values: EppAstb=1, EppDstb=1, EppWr=1, EppDB=Z, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, state IDLE, counters 0.
- Reset asserted mid-cycle: strobes release and EppDB goes to Z asynchronously.
- EppWait is used only through the SYNC_STAGES synchroniser (waitS).
- Output drive:
  - EppDB = latched wdata while a write is active (SETUP through RELEASE); Z otherwise.
  - EppWr is registered from the latched command.
- IDLE:
  - cmd_ready=1.
  - cmd_valid=1 latches addr/write/wdata, sets cmd_ready=0 and goes to SETUP.
  - If waitS=1 at acceptance, still go to SETUP; STROBE does not complete until waitS shows a fresh rise (a low is seen first, tracked by a flag).
- SETUP:
  - EppWr driven, data driven for writes.
  - Count SETUP_CYC cycles, then STROBE.
- STROBE:
  - Selected strobe low.
  - On the first cycle with waitS=1 (after the low flag is satisfied): capture EppDB into the read register for reads, then RELEASE.
  - Counter reaching TIMEOUT_CYC: set the timeout flag, then RELEASE.
- RELEASE:
  - Strobe high, data still driven.
  - Wait for waitS=0, then DONE.
  - Shares the timeout counter (restarted on entry); expiry also goes to DONE with the timeout flag set.
- DONE:
  - One cycle: rsp_valid=1, rsp_rdata = captured byte (0x00 for writes or timeout), rsp_timeout = flag.
  - EppWr returns to 1, EppDB to Z.
  - Next state IDLE; cmd_ready rises the following cycle.
  - Minimum back-to-back spacing: one IDLE cycle.
- Exclusivity: only one strobe is low at a time; never both.
- Latency (write, ideal peripheral): 1 + SETUP_CYC + (sync + peripheral response) + (sync + release) + 1 cycles.
- cmd_valid while busy is ignored; no queueing. Command fields are sampled only at acceptance.
- Timeout counter width: clog2(TIMEOUT_CYC+1); saturates, never wraps.

Decomposition:
- Shared package epp_pkg:
  - State enum (IDLE, SETUP, STROBE, RELEASE, DONE).
  - EPP polarity constants (strobe active level, EppWr write level).
  - Command struct {addr, write, wdata}, shared with the peripheral side.
- One sub-module: epp_sync (SYNC_STAGES-deep bit synchroniser, reset to 0), reused for the peripheral's strobe inputs.

Test Plan:
- Address write 0x02 to a peripheral model (3-cycle Wait response) -> EppAstb low only after SETUP_CYC cycles with EppWr=0 and EppDB=0x02; rsp_valid=1, rsp_timeout=0; model address = 2.
- Data write 0xA5 then data read -> read returns rsp_rdata=0xA5; EppDB=Z throughout the read; EppWr=1 during the read.
- EppWait stuck low -> strobe released after TIMEOUT_CYC cycles; rsp_valid=1 with rsp_timeout=1 and rsp_rdata=0x00; cmd_ready returns to 1.
- EppWait stuck high before the command -> strobe asserts, no completion until Wait pulses low then high; then normal response.
- Four back-to-back commands with cmd_valid held high -> exactly four rsp_valid pulses, one IDLE cycle between cycles, never both strobes low.
- rst pulsed while EppDstb is low -> same cycle: EppDstb=1, EppDB=Z, rsp_valid=0; after release the next command completes normally.
